// File: rtl/cpu_clock_controller_if.sv
// rtl/cpu_clock_controller_if.sv - front-panel/CPU signal bundle for the CPU clock controller
// Ports (master = front panel/CPU side, slave = controller):
//   step_btn, run_btn : debounced button levels, active high
//   rate_sel[1:0]     : run-mode rate select
//   cpu_hlt           : CPU halt level
//   cpu_clk_en        : one-cycle CPU clock-enable pulse
//   mode_run, halted  : mode status
//   pulse_cnt[15:0]   : issued-pulse counter, wraps
interface cpu_clock_controller_if;
    logic        step_btn;
    logic        run_btn;
    logic [1:0]  rate_sel;
    logic        cpu_hlt;
    logic        cpu_clk_en;
    logic        mode_run;
    logic        halted;
    logic [15:0] pulse_cnt;

    modport master (
        output step_btn, run_btn, rate_sel, cpu_hlt,
        input  cpu_clk_en, mode_run, halted, pulse_cnt
    );

    modport slave (
        input  step_btn, run_btn, rate_sel, cpu_hlt,
        output cpu_clk_en, mode_run, halted, pulse_cnt
    );
endinterface

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - CPU clock-enable sequencer: single-step, free-run and halt
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : cpu_clock_controller_if.slave (buttons, rate select, halt in; enable and status out)
module cpu_clock_controller #(
    parameter int DIV_W = 24,
    parameter int DIV0  = 1,
    parameter int DIV1  = 4,
    parameter int DIV2  = 100,
    parameter int DIV3  = 12000000
) (
    input  logic                    clk,
    input  logic                    rst,
    cpu_clock_controller_if.slave   bus
);

    // Terminal-count values (D-1); a divisor of 0 behaves like 1.
    localparam logic [DIV_W-1:0] TC0 = (DIV0 > 1) ? DIV_W'(DIV0 - 1) : '0;
    localparam logic [DIV_W-1:0] TC1 = (DIV1 > 1) ? DIV_W'(DIV1 - 1) : '0;
    localparam logic [DIV_W-1:0] TC2 = (DIV2 > 1) ? DIV_W'(DIV2 - 1) : '0;
    localparam logic [DIV_W-1:0] TC3 = (DIV3 > 1) ? DIV_W'(DIV3 - 1) : '0;

    typedef enum logic [1:0] {
        ST_STEP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              step_prev;
    logic              run_prev;
    logic [DIV_W-1:0]  divider;
    logic [DIV_W-1:0]  divider_next;
    logic [DIV_W-1:0]  tc_val;
    logic              en_next;
    logic              step_edge;
    logic              run_edge;
    logic              tc_hit;
    logic              clk_en_q;
    logic              mode_run_q;
    logic              halted_q;
    logic [15:0]       pulse_cnt_q;

    // prev registers reset to 1 so a button held through reset is not seen as a press.
    assign step_edge = bus.step_btn & ~step_prev;
    assign run_edge  = bus.run_btn  & ~run_prev;

    always_comb begin
        tc_val = TC0;
        case (bus.rate_sel)
            2'd0:    tc_val = TC0;
            2'd1:    tc_val = TC1;
            2'd2:    tc_val = TC2;
            default: tc_val = TC3;
        endcase
    end

    // >= rather than == so a rate change to a smaller divisor wraps at once.
    assign tc_hit = (divider >= tc_val);

    always_comb begin
        state_next   = state;
        divider_next = divider;
        en_next      = 1'b0;
        case (state)
            ST_STEP: begin
                if (bus.cpu_hlt) begin
                    state_next = ST_HALT;
                end else if (run_edge) begin
                    state_next   = ST_RUN;
                    divider_next = '0;
                end else if (step_edge) begin
                    en_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.cpu_hlt) begin
                    state_next = ST_HALT;
                end else if (run_edge) begin
                    state_next   = ST_STEP;
                    divider_next = '0;
                end else if (tc_hit) begin
                    en_next      = 1'b1;
                    divider_next = '0;
                end else begin
                    divider_next = divider + DIV_W'(1);
                end
            end
            ST_HALT: begin
                // Acknowledge is allowed with cpu_hlt still high; STEP then falls straight back to HALT.
                if (run_edge) begin
                    state_next   = ST_STEP;
                    divider_next = '0;
                end
            end
            default: begin
                state_next   = ST_STEP;
                divider_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_STEP;
            step_prev   <= 1'b1;
            run_prev    <= 1'b1;
            divider     <= '0;
            clk_en_q    <= 1'b0;
            mode_run_q  <= 1'b0;
            halted_q    <= 1'b0;
            pulse_cnt_q <= 16'h0000;
        end else begin
            state       <= state_next;
            step_prev   <= bus.step_btn;
            run_prev    <= bus.run_btn;
            divider     <= divider_next;
            clk_en_q    <= en_next;
            mode_run_q  <= (state_next == ST_RUN);
            halted_q    <= (state_next == ST_HALT);
            // Counter moves together with the pulse it counts.
            pulse_cnt_q <= pulse_cnt_q + 16'(en_next);
        end
    end

    assign bus.cpu_clk_en = clk_en_q;
    assign bus.mode_run   = mode_run_q;
    assign bus.halted     = halted_q;
    assign bus.pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - randomized and directed self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_clock_controller_if bus ();

    cpu_clock_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int dut_pulses = 0;

    // Reference model: mode 0=manual, 1=free-run, 2=halted.
    int          m_mode = 0;
    int          m_div = 0;
    bit          m_sp = 1'b1;
    bit          m_rp = 1'b1;
    bit          m_en = 1'b0;
    logic [15:0] m_cnt = 16'h0000;
    int          div_tab [4] = '{1, 4, 100, 12000000};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_div(input logic [1:0] sel);
        return (div_tab[sel] < 1) ? 1 : div_tab[sel];
    endfunction

    task automatic model_clock();
        bit se;
        bit re;
        bit pulse;
        if (rst) begin
            m_mode = 0; m_div = 0; m_sp = 1'b1; m_rp = 1'b1; m_en = 1'b0; m_cnt = 16'h0000;
            return;
        end
        se = bus.step_btn && !m_sp;
        re = bus.run_btn && !m_rp;
        pulse = 1'b0;
        if (m_mode == 2) begin
            if (re) begin m_mode = 0; m_div = 0; end
        end else if (bus.cpu_hlt) begin
            m_mode = 2;
        end else if (re) begin
            m_mode = (m_mode == 0) ? 1 : 0;
            m_div = 0;
        end else if (m_mode == 0) begin
            pulse = se;
        end else if (m_div + 1 >= eff_div(bus.rate_sel)) begin
            pulse = 1'b1;
            m_div = 0;
        end else begin
            m_div = m_div + 1;
        end
        m_en = pulse;
        if (pulse) m_cnt = m_cnt + 16'd1;
        m_sp = bus.step_btn;
        m_rp = bus.run_btn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        if (bus.cpu_clk_en === 1'b1) dut_pulses++;
        check_val("cyc_en",   {31'd0, bus.cpu_clk_en}, {31'd0, m_en});
        check_val("cyc_run",  {31'd0, bus.mode_run},   {31'd0, m_mode == 1});
        check_val("cyc_halt", {31'd0, bus.halted},     {31'd0, m_mode == 2});
        check_val("cyc_cnt",  {16'd0, bus.pulse_cnt},  {16'd0, m_cnt});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_div(input int target, input int limit);
        for (int i = 0; i < limit && m_div != target; i++) tick();
        check_val("wait_div", m_div, target);
    endtask

    task automatic run_edge_pulse();
        bus.run_btn = 1'b0; tick();
        bus.run_btn = 1'b1; tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int first;
        bus.step_btn = 1'b0;
        bus.run_btn  = 1'b1;
        bus.rate_sel = 2'd1;
        bus.cpu_hlt  = 1'b0;
        rst = 1'b1;
        ticks(3);
        check_val("rst_en",   {31'd0, bus.cpu_clk_en}, 32'd0);
        check_val("rst_run",  {31'd0, bus.mode_run},   32'd0);
        check_val("rst_halt", {31'd0, bus.halted},     32'd0);
        check_val("rst_cnt",  {16'd0, bus.pulse_cnt},  32'd0);

        // run_btn held through reset release: no edge.
        rst = 1'b0;
        ticks(5);
        check_val("held_btn_run", {31'd0, bus.mode_run}, 32'd0);
        bus.run_btn = 1'b0;
        tick();

        // Single step: long press then a short one.
        p0 = dut_pulses;
        bus.step_btn = 1'b1; tick();
        check_val("step_lat", {31'd0, bus.cpu_clk_en}, 32'd1);
        tick();
        check_val("step_width", {31'd0, bus.cpu_clk_en}, 32'd0);
        ticks(48);
        bus.step_btn = 1'b0; ticks(3);
        bus.step_btn = 1'b1; ticks(5);
        bus.step_btn = 1'b0; ticks(3);
        check_val("step_pulses", dut_pulses - p0, 32'd2);
        check_val("step_cnt", {16'd0, bus.pulse_cnt}, 32'd2);

        // Free-run at divisor 4.
        bus.rate_sel = 2'd1;
        bus.run_btn = 1'b1; tick();
        check_val("run1_mode", {31'd0, bus.mode_run}, 32'd1);
        p0 = dut_pulses;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.cpu_clk_en === 1'b1 && first < 0) first = i;
        end
        check_val("run1_first", first, 32'd4);
        check_val("run1_pulses", {31'd0, (dut_pulses - p0) >= 9 && (dut_pulses - p0) <= 11}, 32'd1);

        // Back to manual, then free-run continuous, then rate changes.
        run_edge_pulse();
        check_val("run_to_step", {31'd0, bus.mode_run}, 32'd0);
        bus.rate_sel = 2'd0;
        run_edge_pulse();
        p0 = dut_pulses;
        ticks(10);
        check_val("rate0_cont", dut_pulses - p0, 32'd10);
        bus.rate_sel = 2'd2;
        wait_div(60, 200);
        bus.rate_sel = 2'd1;
        tick();
        check_val("rate_chg_wrap", {31'd0, bus.cpu_clk_en}, 32'd1);
        p0 = dut_pulses;
        ticks(12);
        check_val("rate_chg_period", dut_pulses - p0, 32'd3);

        // Halt exactly at terminal count.
        wait_div(3, 20);
        bus.cpu_hlt = 1'b1;
        tick();
        check_val("hlt_no_pulse", {31'd0, bus.cpu_clk_en}, 32'd0);
        check_val("hlt_halted",   {31'd0, bus.halted},     32'd1);
        check_val("hlt_mode_run", {31'd0, bus.mode_run},   32'd0);
        p0 = dut_pulses;
        for (int i = 0; i < 3; i++) begin
            bus.step_btn = 1'b1; ticks(2);
            bus.step_btn = 1'b0; ticks(2);
        end
        check_val("hlt_step_ignored", dut_pulses - p0, 32'd0);
        bus.cpu_hlt = 1'b0;
        run_edge_pulse();
        check_val("hlt_ack_halted", {31'd0, bus.halted},   32'd0);
        check_val("hlt_ack_run",    {31'd0, bus.mode_run}, 32'd0);

        // Run and step rise together in manual mode.
        bus.run_btn = 1'b0; bus.step_btn = 1'b0; tick();
        bus.run_btn = 1'b1; bus.step_btn = 1'b1; tick();
        check_val("simul_run", {31'd0, bus.mode_run},   32'd1);
        check_val("simul_en",  {31'd0, bus.cpu_clk_en}, 32'd0);
        tick();
        check_val("simul_en2", {31'd0, bus.cpu_clk_en}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) bus.step_btn = ~bus.step_btn;
            if ($urandom_range(15, 0) == 0) bus.run_btn = ~bus.run_btn;
            if ($urandom_range(63, 0) == 0) bus.rate_sel = 2'($urandom_range(2, 0));
            if ($urandom_range(49, 0) == 0) bus.cpu_hlt = ~bus.cpu_hlt;
            rst = ($urandom_range(499, 0) == 0);
            tick();
        end
        rst = 1'b0;
        bus.cpu_hlt = 1'b0;
        bus.step_btn = 1'b0;

        // Reset mid-run.
        rst = 1'b1; tick();
        rst = 1'b0;
        bus.rate_sel = 2'd0;
        run_edge_pulse();
        ticks(5);
        rst = 1'b1; tick();
        check_val("midrst_en",   {31'd0, bus.cpu_clk_en}, 32'd0);
        check_val("midrst_run",  {31'd0, bus.mode_run},   32'd0);
        check_val("midrst_halt", {31'd0, bus.halted},     32'd0);
        check_val("midrst_cnt",  {16'd0, bus.pulse_cnt},  32'd0);
        rst = 1'b0;

        // Counter wrap at continuous rate.
        run_edge_pulse();
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
        check_val("wrap_reach", {16'd0, bus.pulse_cnt}, 32'h0000FFFF);
        tick();
        check_val("wrap_zero", {16'd0, bus.pulse_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Sequences the 8-bit CPU clock-enable from the debounced front-panel buttons (debouncer `PB_state` outputs) and the CPU halt line.
- Provides three modes: single-step (manual), free-run at a selectable rate, and halted.
- Output `cpu_clk_en` is a one-cycle enable pulse consumed by all CPU registers in the `clk` domain.
- Also exports mode status and an issued-pulse counter for the front-panel display.

Parameters:
- DIV_W, 24, width of rate divider counter
- DIV0, 1, divisor for rate_sel=0 (pulse every cycle)
- DIV1, 4, divisor for rate_sel=1
- DIV2, 100, divisor for rate_sel=2
- DIV3, 12000000, divisor for rate_sel=3 (must fit DIV_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- step_btn  in  1  debounced step button level, active high, synchronous to clk
- run_btn  in  1  debounced run/stop button level, active high, synchronous to clk
- rate_sel  in  2  run-mode rate select (DIV0..DIV3)
- cpu_hlt  in  1  CPU has executed HLT (level)
- cpu_clk_en  out  1  one-cycle CPU clock-enable pulse, registered
- mode_run  out  1  high while in RUN
- halted  out  1  high while in HALT
- pulse_cnt  out  16  count of cpu_clk_en pulses issued, wraps

Behaviour:
- Reset values: state=STEP, cpu_clk_en=0, mode_run=0, halted=0, pulse_cnt=0, divider=0.
- Edge-detect registers step_prev and run_prev reset to 1. A button held through reset produces no edge until it is released and pressed again.
- Rising edge is defined as btn=1 and prev=1'b0. prev is updated every cycle.
- Priority within a cycle is cpu_hlt > run edge > step edge / terminal count.
- STEP state:
  - A step edge sampled in cycle N gives cpu_clk_en=1 in cycle N+1, for exactly 1 cycle. One pulse per press, however long the button is held.
  - A run edge moves the block to RUN and clears the divider. A step edge in the same cycle is dropped.
  - cpu_hlt=1 moves the block to HALT. No pulse is issued that cycle, even with a step edge.
- RUN state:
  - The divider increments each cycle.
  - Effective divisor D = DIVn selected by rate_sel, with 0 treated as 1.
  - When divider >= D-1: cpu_clk_en=1 next cycle and divider returns to 0.
  - D=1 gives continuous cpu_clk_en=1. The first pulse comes D cycles after entering RUN.
  - A rate_sel change mid-run takes effect immediately. The >= compare guarantees a wrap, with no 2^DIV_W stall.
  - A run edge moves the block to STEP and clears the divider. No pulse is issued that cycle, even at terminal count.
  - Step edges are ignored.
  - cpu_hlt=1 moves the block to HALT and suppresses any pulse due that cycle.
- HALT state:
  - No pulses are issued. Step edges are ignored.
  - A run edge moves the block to STEP (acknowledge/resume manual) and clears the divider. This transition is allowed even while cpu_hlt stays high. If cpu_hlt is still 1 the next cycle, the block returns to HALT, so the CPU must be reset to leave HALT for good.
- mode_run and halted are registered and reflect the state after the transition (1 cycle after the causing input).
- pulse_cnt increments by 1 in each cycle where cpu_clk_en=1, wraps FFFF->0000, and is cleared only by rst.
- rst=1 at any point, including mid-run or mid-pulse, returns all registers to their reset values on the next edge. cpu_clk_en is 0 in the cycle after rst is sampled.

Test Plan:
- Step:
  - Stimulus: after reset, press step_btn for 50 cycles, release, press again.
  - Required: exactly 2 cpu_clk_en pulses, each 1 cycle wide, each 1 cycle after the rising edge; pulse_cnt=2.
- Run at rate_sel=1:
  - Stimulus: run edge, hold 40 cycles.
  - Required: mode_run=1; pulses every 4th cycle, first 4 cycles after entry; 10 pulses ±1.
- Run at rate_sel=0, then rate change:
  - Stimulus: run at rate_sel=0 for 10 cycles, switch to rate_sel=2, then back to rate_sel=1 while divider=60.
  - Required: continuous enable for the first 10 cycles; the next pulse occurs on the following cycle and divider is 0; period 4 thereafter.
- Halt:
  - Stimulus: in RUN, assert cpu_hlt in the same cycle as a terminal count.
  - Required: no pulse; halted=1, mode_run=0; step edges give no pulses; a run edge with cpu_hlt=0 gives STEP, halted=0.
- Held button across reset:
  - Stimulus: run_btn held high through rst deassertion.
  - Required: state stays STEP.
- Simultaneous edges:
  - Stimulus: run_btn and step_btn rise in the same cycle while in STEP.
  - Required: enter RUN with no step pulse.
- Reset mid-run and counter wrap:
  - Stimulus: rst mid-run; then preload to 65535 pulses at rate_sel=0.
  - Required: all outputs 0 after rst; pulse_cnt wraps to 0.
